zxuno_flash_spi: RTL and testbench

//  SPI master for the boot/config flash behind ZX-Uno registers $02 (data) and $03 (CS).

---
 rtl/zxuno_flash_spi_pkg.sv | 22 ++
 rtl/flash_spi_shifter.sv | 109 ++++++++++
 rtl/zxuno_flash_spi.sv | 135 +++++++++++++
 tb/tb_zxuno_flash_spi.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zxuno_flash_spi_pkg.sv
// Shared definitions for the ZX-Uno flash SPI master.
//  - ZX-Uno register numbers used by the register-address decoder.
//  - Default SPI clock divider.
//  - Shifter state encoding.
package zxuno_flash_spi_pkg;

    // ZX-Uno register map (register numbers seen on addr).
    localparam logic [7:0] REG_MASTER_CFG = 8'h00;
    localparam logic [7:0] REG_MAPPER     = 8'h01;
    localparam logic [7:0] REG_SPI_DATA   = 8'h02;
    localparam logic [7:0] REG_SPI_CS     = 8'h03;
    localparam logic [7:0] REG_SCANCODE   = 8'h04;

    // flash_clk half-period in clk cycles.
    localparam int SPI_CLKDIV_DEFAULT = 2;

    typedef enum logic {
        SPI_IDLE  = 1'b0,
        SPI_SHIFT = 1'b1
    } spi_state_e;

endpackage

// File: rtl/flash_spi_shifter.sv
// Byte shifter for the flash SPI master (SPI mode 0, MSB first).
// Ports:
//  clk, rst   system clock, asynchronous active-high reset
//  start      launch a byte; accepted when idle or on the completion clk
//  tx         byte to send, captured with start
//  busy       1 while the byte is shifting
//  done       single-clk pulse on the clk that ends the transfer
//  rx         last complete received byte (updated only on completion)
//  miso       serial data in, sampled on flash_clk rising edges
//  mosi       serial data out, changes on flash_clk falling edges
//  sclk       flash_clk, idle low, toggles every CLKDIV clks while busy
module flash_spi_shifter
    import zxuno_flash_spi_pkg::*;
#(
    parameter int CLKDIV = SPI_CLKDIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tx,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx,
    input  logic       miso,
    output logic       mosi,
    output logic       sclk
);

    localparam int                DIV_W    = $clog2(CLKDIV) + 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLKDIV - 1);

    spi_state_e        state_q;
    spi_state_e        state_d;
    logic [DIV_W-1:0]  div_cnt;
    logic [3:0]        bit_cnt;   // counts flash_clk toggles, 16 per byte
    logic [7:0]        tx_sh;     // bits still to be presented, 1s shifted in
    logic [7:0]        rx_sh;
    logic              tick;
    logic              load;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        state_d = state_q;
        tick    = 1'b0;
        done    = 1'b0;
        case (state_q)
            SPI_IDLE: begin
                if (start) state_d = SPI_SHIFT;
            end
            SPI_SHIFT: begin
                tick = (div_cnt == DIV_LAST);
                if (tick && bit_cnt == 4'd15) begin
                    done    = 1'b1;
                    // A start on the completion clk chains straight into the next byte.
                    state_d = start ? SPI_SHIFT : SPI_IDLE;
                end
            end
            default: state_d = SPI_IDLE;
        endcase
    end

    assign busy = (state_q == SPI_SHIFT);
    assign load = start && (state_q == SPI_IDLE || done);

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= SPI_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            tx_sh   <= 8'hFF;
            rx_sh   <= 8'hFF;
            rx      <= 8'hFF;
            mosi    <= 1'b1;
            sclk    <= 1'b0;
        end else begin
            // The last sample was taken on toggle 15, so rx_sh is complete here.
            if (done) rx <= rx_sh;

            if (load) begin
                tx_sh   <= {tx[6:0], 1'b1};
                mosi    <= tx[7];
                sclk    <= 1'b0;
                div_cnt <= '0;
                bit_cnt <= '0;
            end else if (busy) begin
                if (tick) begin
                    div_cnt <= '0;
                    sclk    <= ~sclk;
                    bit_cnt <= bit_cnt + 4'd1;  // wraps to 0 only on the final toggle
                    if (!sclk) begin
                        rx_sh <= {rx_sh[6:0], miso};
                    end else begin
                        // After the eighth bit this leaves mosi at the idle-high level.
                        mosi  <= tx_sh[7];
                        tx_sh <= {tx_sh[6:0], 1'b1};
                    end
                end else begin
                    div_cnt <= div_cnt + DIV_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/zxuno_flash_spi.sv
// SPI master for the ZX-Uno boot/config flash behind registers $02 (data) and $03 (CS).
// Build option: define SPI_READ_STARTS_XFER_EN to make a read of the data register return
// the current rx and then launch a transfer of 8'hFF (read-through streaming).
// Ports:
//  clk, rst                       system clock, asynchronous active-high reset
//  addr                           selected ZX-Uno register number
//  read_from_reg, write_to_reg    CPU access levels; acted on at their rising edge
//  din                            CPU data bus
//  dout, oe_n                     read data (8'hFF when idle) and its enable, active low
//  busy                           byte shifting
//  flash_cs_n, flash_clk,
//  flash_mosi, flash_miso         flash pins
module zxuno_flash_spi
    import zxuno_flash_spi_pkg::*;
#(
    parameter logic [7:0] SPIREG = REG_SPI_DATA,
    parameter logic [7:0] CSREG  = REG_SPI_CS,
    parameter int         CLKDIV = SPI_CLKDIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] addr,
    input  logic       read_from_reg,
    input  logic       write_to_reg,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       oe_n,
    output logic       busy,
    output logic       flash_cs_n,
    output logic       flash_clk,
    output logic       flash_mosi,
    input  logic       flash_miso
);

    logic       wr_q;
    logic       rd_q;
    logic       wr_edge;
    logic       rd_edge;
    logic       spi_wr_edge;
    logic       cs_wr_edge;
    logic       cs_rd_edge;
    logic       rd_start;
    logic       wr_accept;
    logic       start;
    logic [7:0] tx_data;
    logic       done;
    logic [7:0] rx;
    logic       overrun;
    logic       cs_pending;
    logic       cs_pending_val;

    // Strobes span many clks; one CPU access must give exactly one action.
    assign wr_edge     = write_to_reg  && !wr_q;
    assign rd_edge     = read_from_reg && !rd_q;
    assign spi_wr_edge = wr_edge && (addr == SPIREG);
    assign cs_wr_edge  = wr_edge && (addr == CSREG);
    assign cs_rd_edge  = rd_edge && (addr == CSREG);

`ifdef SPI_READ_STARTS_XFER_EN
    logic spi_rd_edge;
    assign spi_rd_edge = rd_edge && (addr == SPIREG);
    // Reads during a transfer only return rx; they never queue or flag overrun.
    assign rd_start    = spi_rd_edge && !busy;
`else
    assign rd_start    = 1'b0;
`endif

    // On the completion clk the byte finishes first, so a write there is not an overrun.
    assign wr_accept = spi_wr_edge && (!busy || done);
    assign start     = wr_accept || rd_start;
    assign tx_data   = wr_accept ? din : 8'hFF;

    flash_spi_shifter #(
        .CLKDIV (CLKDIV)
    ) u_shifter (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .tx    (tx_data),
        .busy  (busy),
        .done  (done),
        .rx    (rx),
        .miso  (flash_miso),
        .mosi  (flash_mosi),
        .sclk  (flash_clk)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q           <= 1'b0;
            rd_q           <= 1'b0;
            overrun        <= 1'b0;
            flash_cs_n     <= 1'b1;
            cs_pending     <= 1'b0;
            cs_pending_val <= 1'b1;
        end else begin
            wr_q <= write_to_reg;
            rd_q <= read_from_reg;

            // Set has priority over the status-read clear.
            if (spi_wr_edge && busy && !done) overrun <= 1'b1;
            else if (cs_rd_edge)              overrun <= 1'b0;

            // CS never changes mid-byte; a write while busy waits for completion,
            // and a newer write while busy replaces the waiting value.
            if (cs_wr_edge) begin
                if (!busy || done) begin
                    flash_cs_n <= din[0];
                    cs_pending <= 1'b0;
                end else begin
                    cs_pending     <= 1'b1;
                    cs_pending_val <= din[0];
                end
            end else if (done && cs_pending) begin
                flash_cs_n <= cs_pending_val;
                cs_pending <= 1'b0;
            end
        end
    end

    always_comb begin
        dout = 8'hFF;
        oe_n = 1'b1;
        if (read_from_reg) begin
            if (addr == SPIREG) begin
                dout = rx;
                oe_n = 1'b0;
            end else if (addr == CSREG) begin
                dout = {overrun, 6'b0, flash_cs_n};
                oe_n = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_zxuno_flash_spi.sv
// Self-checking bench for zxuno_flash_spi (default parameters, CLKDIV = 2).
module tb_zxuno_flash_spi;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] addr;
    logic       read_from_reg;
    logic       write_to_reg;
    logic [7:0] din;
    logic [7:0] dout;
    logic       oe_n;
    logic       busy;
    logic       flash_cs_n;
    logic       flash_clk;
    logic       flash_mosi;
    logic       flash_miso;

    int n_cmp = 0;
    int n_err = 0;

    zxuno_flash_spi dut (
        .clk           (clk),
        .rst           (rst),
        .addr          (addr),
        .read_from_reg (read_from_reg),
        .write_to_reg  (write_to_reg),
        .din           (din),
        .dout          (dout),
        .oe_n          (oe_n),
        .busy          (busy),
        .flash_cs_n    (flash_cs_n),
        .flash_clk     (flash_clk),
        .flash_mosi    (flash_mosi),
        .flash_miso    (flash_miso)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] tx;
        logic [7:0] miso;
        logic [7:0] exp_mosi;
        logic [7:0] exp_rx;
        int         exp_busy;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic reg_write(input logic [7:0] a, input logic [7:0] d);
        addr = a; din = d; write_to_reg = 1'b1;
        @(negedge clk);
        write_to_reg = 1'b0;
        @(negedge clk);
    endtask

    task automatic read_reg(input logic [7:0] a, output logic [7:0] d, output logic oe);
        addr = a; read_from_reg = 1'b1;
        #1;
        d  = dout;
        oe = oe_n;
        @(negedge clk);
        read_from_reg = 1'b0;
        @(negedge clk);
    endtask

    // Counts busy negedges until busy drops; bounded.
    task automatic wait_idle(output int cycles);
        cycles = 0;
        for (int c = 0; c < 100; c++) begin
            if (!busy) break;
            cycles++;
            @(negedge clk);
        end
    endtask

    // Runs one byte with a flash model: miso presents the next bit after each
    // flash_clk rise; mosi is captured at each rise.
    task automatic do_xfer(input logic use_read, input logic [7:0] tx, input logic [7:0] miso_byte,
                           input int hold, output logic [7:0] mosi_got, output logic [7:0] dout_start,
                           output int busy_cycles, output int rises);
        logic prev_sclk;
        int   idx;
        mosi_got    = '0;
        busy_cycles = 0;
        rises       = 0;
        idx         = 0;
        flash_miso  = miso_byte[7];
        addr = 8'h02; din = tx;
        if (use_read) read_from_reg = 1'b1;
        else          write_to_reg  = 1'b1;
        #1;
        dout_start = dout;
        prev_sclk  = flash_clk;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (c >= hold) begin
                read_from_reg = 1'b0;
                write_to_reg  = 1'b0;
            end
            if (busy) busy_cycles++;
            if (flash_clk && !prev_sclk) begin
                mosi_got = {mosi_got[6:0], flash_mosi};
                rises++;
                idx++;
                flash_miso = (idx < 8) ? miso_byte[7-idx] : 1'b1;
            end
            prev_sclk = flash_clk;
            if (!busy) break;
        end
        read_from_reg = 1'b0;
        write_to_reg  = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] d;
        logic       oe;
        logic [7:0] mg;
        logic [7:0] ds;
        int         bc;
        int         rc;
        int         seen;
        logic       cs_ok;

        vecs[0] = '{8'hA5, 8'h3C, 8'hA5, 8'h3C, 32};
        vecs[1] = '{8'h00, 8'hFF, 8'h00, 8'hFF, 32};
        vecs[2] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 32};
        vecs[3] = '{8'h81, 8'h7E, 8'h81, 8'h7E, 32};
        vecs[4] = '{8'h5A, 8'hC3, 8'h5A, 8'hC3, 32};

        rst = 1'b1; addr = 8'h00; din = 8'h00;
        read_from_reg = 1'b0; write_to_reg = 1'b0; flash_miso = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_cs_n", {31'd0, flash_cs_n}, 32'd1);
        check("rst_sclk", {31'd0, flash_clk},  32'd0);
        check("rst_mosi", {31'd0, flash_mosi}, 32'd1);
        check("rst_busy", {31'd0, busy},       32'd0);
        check("rst_oe_n_idle", {31'd0, oe_n},  32'd1);
        rst = 1'b0;
        @(negedge clk);
        read_reg(8'h03, d, oe);
        check("rst_rd03", {24'd0, d}, 32'h01);
        check("rst_rd03_oe", {31'd0, oe}, 32'd0);
        read_reg(8'h02, d, oe);
        check("rst_rd02", {24'd0, d}, 32'hFF);
        read_reg(8'h04, d, oe);
        check("other_reg_oe_n", {31'd0, oe}, 32'd1);

        reg_write(8'h03, 8'h00);
        check("cs_low", {31'd0, flash_cs_n}, 32'd0);

        // Table of single-byte transfers
        for (int i = 0; i < 5; i++) begin
            do_xfer(1'b0, vecs[i].tx, vecs[i].miso, 1, mg, ds, bc, rc);
            check($sformatf("v%0d_mosi", i), {24'd0, mg}, {24'd0, vecs[i].exp_mosi});
            check($sformatf("v%0d_busy", i), bc, vecs[i].exp_busy);
            check($sformatf("v%0d_rises", i), rc, 8);
            check($sformatf("v%0d_dout_wr", i), {24'd0, ds}, 32'hFF);
            check($sformatf("v%0d_idle_sclk", i), {31'd0, flash_clk}, 32'd0);
            read_reg(8'h02, d, oe);
            check($sformatf("v%0d_rx", i), {24'd0, d}, {24'd0, vecs[i].exp_rx});
        end

`ifdef SPI_READ_STARTS_XFER_EN
        // Read-through: returns previous rx and sends 8'hFF
        do_xfer(1'b1, 8'h00, 8'h69, 1, mg, ds, bc, rc);
        check("rt_first_dout", {24'd0, ds}, 32'hC3);
        check("rt_mosi", {24'd0, mg}, 32'hFF);
        check("rt_busy", bc, 32);
        flash_miso = 1'b1;
        read_reg(8'h02, d, oe);
        check("rt_second_dout", {24'd0, d}, 32'h69);
        check("rt_second_starts", {31'd0, busy}, 32'd1);
        read_reg(8'h02, d, oe);
        check("rt_read_busy_dout", {24'd0, d}, 32'h69);
        wait_idle(bc);
        repeat (3) @(negedge clk);
        check("rt_no_chain", {31'd0, busy}, 32'd0);
        read_reg(8'h03, d, oe);
        check("rt_no_overrun", {24'd0, d}, 32'h00);
`else
        read_reg(8'h02, d, oe);
        check("rd02_no_xfer", {31'd0, busy}, 32'd0);
`endif

        // Held write strobe: exactly one transfer
        do_xfer(1'b0, 8'h3C, 8'h96, 20, mg, ds, bc, rc);
        check("hold_busy", bc, 32);
        check("hold_mosi", {24'd0, mg}, 32'h3C);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (busy) seen++;
        end
        check("hold_single", seen, 0);
        read_reg(8'h02, d, oe);
        check("hold_rx", {24'd0, d}, 32'h96);
        read_reg(8'h03, d, oe);
        check("hold_no_overrun", {24'd0, d}, 32'h00);

        // Overrun: write during busy is dropped
        flash_miso = 1'b0;
        reg_write(8'h02, 8'hA5);
        repeat (3) @(negedge clk);
        reg_write(8'h02, 8'h11);
        read_reg(8'h03, d, oe);
        check("ovr_set", {24'd0, d}, 32'h80);
        read_reg(8'h03, d, oe);
        check("ovr_clear", {24'd0, d}, 32'h00);
        wait_idle(bc);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (busy) seen++;
        end
        check("ovr_dropped", seen, 0);
        read_reg(8'h02, d, oe);
        check("ovr_rx", {24'd0, d}, 32'h00);

        // CS write during busy waits for busy to fall
        addr = 8'h02; din = 8'h42; write_to_reg = 1'b1;
        @(negedge clk);
        write_to_reg = 1'b0;
        repeat (3) @(negedge clk);
        reg_write(8'h03, 8'h01);
        cs_ok = 1'b1;
        d     = 8'h00;
        for (int c = 0; c < 100; c++) begin
            if (!busy) begin
                d = {7'd0, flash_cs_n};
                break;
            end
            if (flash_cs_n !== 1'b0) cs_ok = 1'b0;
            @(negedge clk);
        end
        check("cs_pending_hold", {31'd0, cs_ok}, 32'd1);
        check("cs_apply_at_fall", {24'd0, d}, 32'h01);

        // Write edge on the completion clk is accepted, no overrun
        addr = 8'h02; din = 8'h0F; write_to_reg = 1'b1;
        @(negedge clk);
        write_to_reg = 1'b0;
        repeat (31) @(negedge clk);
        din = 8'h5A; write_to_reg = 1'b1;
        @(negedge clk);
        write_to_reg = 1'b0;
        check("done_wr_started", {31'd0, busy}, 32'd1);
        wait_idle(bc);
        check("done_wr_busy", bc, 32);
        read_reg(8'h03, d, oe);
        check("done_wr_no_overrun", {24'd0, d}, 32'h01);

        // Reset mid-transfer
        reg_write(8'h03, 8'h00);
        addr = 8'h02; din = 8'h00; write_to_reg = 1'b1;
        @(negedge clk);
        write_to_reg = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_cs_n", {31'd0, flash_cs_n}, 32'd1);
        check("mid_rst_sclk", {31'd0, flash_clk},  32'd0);
        check("mid_rst_mosi", {31'd0, flash_mosi}, 32'd1);
        check("mid_rst_busy", {31'd0, busy},       32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        read_reg(8'h02, d, oe);
        check("mid_rst_rx", {24'd0, d}, 32'hFF);
        read_reg(8'h03, d, oe);
        check("mid_rst_rd03", {24'd0, d}, 32'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
